// File: rtl/bit_serializer_64_if.sv
// Purpose : word-in / bit-out stream bundle for bit_serializer_64.
// Ports   : in_valid/in_ready/in_data/in_len (word side), out_valid/out_ready/out_bit/out_last (bit side).
// Modports: master = producer+consumer side, slave = serializer side.
interface bit_serializer_64_if;
  // word side
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [5:0]  in_len;
  // bit side
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        out_last;

  modport master (
    output in_valid, in_data, in_len, out_ready,
    input  in_ready, out_valid, out_bit, out_last
  );

  modport slave (
    input  in_valid, in_data, in_len, out_ready,
    output in_ready, out_valid, out_bit, out_last
  );
endinterface

// File: rtl/bit_serializer_64.sv
// Purpose : latch a 64-bit word and stream len+1 of its bits, one per accepted beat, via a 64:1 mux.
// Latency : word accepted at edge N, first bit valid in cycle N+1; in_ready returns the cycle after the last beat.
// Backpr. : out_ready low freezes idx/cnt/out_bit/out_last; no new word is accepted until the current one drains.
// Ports   : clock, reset (sync, active-low), bus (slave modport of bit_serializer_64_if), busy (high while sending).

// 64:1 single-bit mux; select picks data_i[sel_i].
module mux_64_1_bit (
  input  logic [5:0]  sel_i,
  input  logic [63:0] data_i,
  output logic        bit_o
);
  assign bit_o = data_i[sel_i];
endmodule

module bit_serializer_64 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  bit_serializer_64_if.slave bus,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;   // mux select: bit position currently presented
  logic [5:0]  cnt_q, cnt_d;   // beats already accepted for this word
  logic [5:0]  len_q, len_d;   // bits in word minus one
  logic [63:0] data_q, data_d;
  logic        mux_bit;
  logic        last;

  mux_64_1_bit u_mux (
    .sel_i  (idx_q),
    .data_i (data_q),
    .bit_o  (mux_bit)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 6'd0;
      cnt_q   <= 6'd0;
      len_q   <= 6'd0;
      data_q  <= 64'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    data_d        = data_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    busy          = 1'b0;
    last          = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          data_d  = bus.in_data;
          len_d   = bus.in_len;
          // MSB-first walks down from the top requested bit to bit 0
          idx_d   = MSB_FIRST ? bus.in_len : 6'd0;
          cnt_d   = 6'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        busy          = 1'b1;
        last          = (cnt_q == len_q);
        bus.out_last  = last;
        // With out_ready low nothing advances, so the presented beat is frozen.
        if (bus.out_ready) begin
          if (last) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 6'd1;
            idx_d = MSB_FIRST ? (idx_q - 6'd1) : (idx_q + 6'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // data_q may hold a stale word while idle; gate so the line reads 0 without a beat.
  assign bus.out_bit = mux_bit & bus.out_valid;

  // idx is fully determined by cnt and the walking direction; cnt never passes len.
  a_cnt_bound: assert property (@(posedge clock) disable iff (!reset)
    (state_q == SEND) |-> (cnt_q <= len_q));

  a_idx_track: assert property (@(posedge clock) disable iff (!reset)
    (state_q == SEND) |-> (idx_q == (MSB_FIRST ? (len_q - cnt_q) : cnt_q)));

  a_hold: assert property (@(posedge clock) disable iff (!reset)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(idx_q) && $stable(cnt_q)));

endmodule

// File: tb/tb_bit_serializer_64.sv
// Purpose : scoreboard bench for bit_serializer_64, one LSB-first and one MSB-first instance.
// Latency : expected beats are queued at word acceptance and popped by per-instance monitors.
// Backpr. : out_ready is driven constant, random or from an explicit pattern.
module tb_bit_serializer_64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n [2];
  logic busy0, busy1;
  logic or_val;
  int   or_mode;   // 0: always ready, 1: random, 2: driven by main sequence

  bit_serializer_64_if if0 ();
  bit_serializer_64_if if1 ();

  assign if0.out_ready = or_val;
  assign if1.out_ready = or_val;

  bit_serializer_64 #(.MSB_FIRST(1'b0)) u_lsb (
    .clock (clk), .reset (rst_n[0]), .bus (if0), .busy (busy0));
  bit_serializer_64 #(.MSB_FIRST(1'b1)) u_msb (
    .clock (clk), .reset (rst_n[1]), .bus (if1), .busy (busy1));

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0] q0 [$];   // {bit, last}
  logic [1:0] q1 [$];
  bit   hold   [2];
  logic prev_b [2];
  logic prev_l [2];
  int   beats  [2];

  task automatic chk(input bit ok, input string name, input int d,
                     input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h", name, d, act, exp);
    end
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic qpush(input int d, input logic [1:0] v);
    if (d == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qflush(input int d);
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  task automatic mon(input int d, input logic rs, input logic ov, input logic ir,
                     input logic ob, input logic ol, input logic rdy, input logic bz);
    logic [1:0] e;
    if (rs !== 1'b1) begin
      hold[d] = 1'b0;
      return;
    end
    chk(ir === !ov, "in_ready_vs_out_valid", d, {63'd0, ir}, {63'd0, !ov});
    chk(bz === ov, "busy_vs_out_valid", d, {63'd0, bz}, {63'd0, ov});
    if (ov !== 1'b1) chk(ob === 1'b0 && ol === 1'b0, "idle_outputs_zero", d, {62'd0, ob, ol}, 64'd0);
    if (hold[d]) begin
      chk(ov === 1'b1 && ob === prev_b[d] && ol === prev_l[d], "hold_stable", d,
          {61'd0, ov, ob, ol}, {61'd0, 1'b1, prev_b[d], prev_l[d]});
    end
    if (ov === 1'b1 && rdy === 1'b1) begin
      beats[d]++;
      if (qsize(d) == 0) begin
        chk(1'b0, "unexpected_beat", d, {62'd0, ob, ol}, 64'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk({ob, ol} === e, "beat_bit_last", d, {62'd0, ob, ol}, {62'd0, e});
      end
    end
    hold[d]   = (ov === 1'b1) && (rdy === 1'b0);
    prev_b[d] = ob;
    prev_l[d] = ol;
  endtask

  always @(negedge clk) mon(0, rst_n[0], if0.out_valid, if0.in_ready, if0.out_bit, if0.out_last, if0.out_ready, busy0);
  always @(negedge clk) mon(1, rst_n[1], if1.out_valid, if1.in_ready, if1.out_bit, if1.out_last, if1.out_ready, busy1);

  always @(posedge clk) begin
    #1;
    if (or_mode == 0) or_val = 1'b1;
    else if (or_mode == 1) or_val = 1'($urandom_range(0, 1));
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout dut0: got 0x0 expected 0x1");
    $fatal(1, "simulation time limit");
  end

  task automatic drive(input int d, input logic v, input logic [63:0] data, input logic [5:0] len);
    if (d == 0) begin if0.in_valid = v; if0.in_data = data; if0.in_len = len; end
    else        begin if1.in_valid = v; if1.in_data = data; if1.in_len = len; end
  endtask

  function automatic logic get_ir(input int d);
    return (d == 0) ? if0.in_ready : if1.in_ready;
  endfunction

  function automatic logic get_ov(input int d);
    return (d == 0) ? if0.out_valid : if1.out_valid;
  endfunction

  function automatic logic get_ob(input int d);
    return (d == 0) ? if0.out_bit : if1.out_bit;
  endfunction

  function automatic logic get_bz(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction

  // Reference: bit i of the stream is data[i] (LSB-first) or data[len-i] (MSB-first).
  task automatic send_word(input int d, input logic [63:0] data, input logic [5:0] len, input bit lat);
    int cyc;
    int pos;
    @(posedge clk); #1;
    drive(d, 1'b1, data, len);
    cyc = 0;
    @(negedge clk);
    while (get_ir(d) !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
    chk(cyc < 300, "accept_timeout", d, cyc, 300);
    @(posedge clk);
    for (int i = 0; i <= int'(len); i++) begin
      pos = (d == 1) ? (int'(len) - i) : i;
      qpush(d, {data[pos], (i == int'(len))});
    end
    #1;
    // scramble the inputs: the word in flight must not follow them
    drive(d, 1'b0, {$urandom, $urandom}, 6'($urandom));
    @(negedge clk);
    chk(get_ov(d) === 1'b1, "first_bit_valid", d, {63'd0, get_ov(d)}, 64'd1);
    if (lat) begin
      cyc = 1;
      while (get_ir(d) !== 1'b1 && cyc < 300) begin @(negedge clk); cyc++; end
      chk(cyc == int'(len) + 2, "ready_return_latency", d, cyc, int'(len) + 2);
    end
  endtask

  task automatic wait_idle(input int d);
    int cyc;
    cyc = 0;
    @(negedge clk);
    while ((get_ir(d) !== 1'b1 || qsize(d) != 0) && cyc < 1000) begin @(negedge clk); cyc++; end
    chk(qsize(d) == 0 && get_ir(d) === 1'b1, "drain", d, qsize(d), 0);
  endtask

  task automatic check_reset_vals(input int d, input string tag);
    chk(get_ir(d) === 1'b1, {tag, "_in_ready"}, d, {63'd0, get_ir(d)}, 64'd1);
    chk(get_ov(d) === 1'b0, {tag, "_out_valid"}, d, {63'd0, get_ov(d)}, 64'd0);
    chk(get_ob(d) === 1'b0, {tag, "_out_bit"}, d, {63'd0, get_ob(d)}, 64'd0);
    chk(get_bz(d) === 1'b0, {tag, "_busy"}, d, {63'd0, get_bz(d)}, 64'd0);
  endtask

  initial begin
    bit pat [7];
    int b0;
    logic [5:0] rl;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    or_mode = 0; or_val = 1'b1;
    drive(0, 1'b0, 64'd0, 6'd0);
    drive(1, 1'b0, 64'd0, 6'd0);

    // reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals(0, "reset");
    check_reset_vals(1, "reset");
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // LSB-first 0xA5, 8 bits
    send_word(0, 64'h0000_0000_0000_00A5, 6'd7, 1'b1);
    wait_idle(0);

    // single bit, upper bits noisy
    send_word(0, {$urandom, $urandom} | 64'h1, 6'd0, 1'b1);
    wait_idle(0);

    // backpressure pattern on 4'b0110
    or_mode = 2; or_val = 1'b1;
    send_word(0, {$urandom, $urandom[27:0], 4'b0110}, 6'd3, 1'b0);
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); #1;
      or_val = pat[k];
    end
    wait_idle(0);
    or_mode = 0;

    // MSB-first full 64-bit word
    send_word(1, 64'h8000_0000_0000_0001, 6'd63, 1'b1);
    wait_idle(1);

    // MSB-first single bit
    send_word(1, 64'h1, 6'd0, 1'b1);
    wait_idle(1);

    // reset after 5 handshakes of a 16-bit word
    send_word(0, {$urandom, $urandom}, 6'd15, 1'b0);
    b0 = beats[0];
    repeat (4) @(posedge clk);
    #1;
    rst_n[0] = 1'b0;
    qflush(0);
    @(negedge clk);
    chk(beats[0] - b0 == 4, "beats_before_reset", 0, beats[0] - b0 + 1, 5);
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_reset_vals(0, "mid_reset");
    send_word(0, 64'h2, 6'd1, 1'b1);
    wait_idle(0);

    // reset coincident with an offered word: reset wins
    @(posedge clk); #1;
    drive(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 6'd5);
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    drive(0, 1'b0, 64'd0, 6'd0);
    @(negedge clk);
    check_reset_vals(0, "reset_vs_accept");

    // random words with random backpressure on both instances
    or_mode = 1;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        rl = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 15));
        send_word(d, {$urandom, $urandom}, rl, 1'b0);
        if ($urandom_range(0, 1) == 1) wait_idle(d);
      end
      wait_idle(d);
    end
    or_mode = 0;

    repeat (3) @(negedge clk);
    chk(q0.size() == 0, "final_queue_empty", 0, q0.size(), 0);
    chk(q1.size() == 0, "final_queue_empty", 1, q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
